// File: rtl/wfg_pkg.sv
// Shared types and constants for the waveform-generator control path.
// Used by the UART command decoder and the register bank controller.
package wfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_ADDR,
        S_W_ADDR,
        S_TX_DATA,
        S_W_DATA
    } state_t;

    localparam int STATUS_RD_OVF_BIT = 0;
    localparam int STATUS_WR_OOR_BIT = 1;

    // ASCII opcodes recognised by the command decoder.
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

endpackage

// File: rtl/reg_bank_file.sv
// NUM_REGS x 8 configuration storage: one write port, flat output,
// asynchronous read mux.
module reg_bank_file #(
    parameter int NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [7:0]            waddr_i,
    input  logic [7:0]            wdata_i,
    input  logic [7:0]            raddr_i,
    output logic [7:0]            rdata_o,
    output logic [NUM_REGS*8-1:0] regs_o
);

    logic [7:0] mem_q [NUM_REGS];
    logic [7:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (we_i && waddr_i == 8'(k)) begin
                mem_d[k] = wdata_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                mem_q[k] <= 8'h00;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rdata_o = 8'h00;
        regs_o  = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_o[8*k +: 8] = mem_q[k];
            if (raddr_i == 8'(k)) begin
                rdata_o = mem_q[k];
            end
        end
    end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Register bank plus read-response sequencer: each accepted read is
// returned over the UART as an (address, data) byte pair.
import wfg_pkg::*;

module reg_bank_ctrl #(
    parameter int         NUM_REGS    = 16,
    parameter logic [7:0] ERR_BYTE    = 8'hEE,
    parameter logic [7:0] STATUS_ADDR = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic [7:0]            addr_i,
    input  logic [7:0]            wdata_i,
    input  logic                  tx_done_i,
    output logic                  tx_start_o,
    output logic [7:0]            tx_data_o,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  upd_o,
    output logic [7:0]            upd_addr_o,
    output logic                  busy_o
);

    localparam logic [7:0] LAST_ADDR = 8'(NUM_REGS - 1);

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] snap_q, snap_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       slot_v_q, slot_v_d;
    logic [7:0] slot_addr_q, slot_addr_d;
    logic [1:0] status_q, status_d;
    logic       upd_q, upd_d;
    logic [7:0] upd_addr_q, upd_addr_d;

    logic       wr_ok;
    logic       launch;
    logic [7:0] launch_addr;
    logic       ovf_set;
    logic       status_clr;
    logic [7:0] rd_data;
    logic [7:0] snap_val;

    assign wr_ok = wr_en_i && (addr_i <= LAST_ADDR);

    reg_bank_file #(
        .NUM_REGS(NUM_REGS)
    ) u_file (
        .clk    (clk),
        .rst    (rst),
        .we_i   (wr_ok),
        .waddr_i(addr_i),
        .wdata_i(wdata_i),
        .raddr_i(addr_q),
        .rdata_o(rd_data),
        .regs_o (regs_o)
    );

    // Mapped range and STATUS_ADDR never overlap.
    always_comb begin
        unique case (1'b1)
            addr_q <= LAST_ADDR:    snap_val = rd_data;
            addr_q == STATUS_ADDR:  snap_val = {6'b0, status_q};
            default:                snap_val = ERR_BYTE;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        snap_d      = snap_q;
        tx_data_d   = tx_data_q;
        slot_v_d    = slot_v_q;
        slot_addr_d = slot_addr_q;
        launch      = 1'b0;
        launch_addr = addr_i;
        ovf_set     = 1'b0;
        status_clr  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                launch = slot_v_q || rd_en_i;
            end
            S_TX_ADDR: begin
                snap_d     = snap_val;
                status_clr = (addr_q == STATUS_ADDR);
                state_d    = S_W_ADDR;
            end
            S_W_ADDR: begin
                if (tx_done_i) begin
                    tx_data_d = snap_q;
                    state_d   = S_TX_DATA;
                end
            end
            S_TX_DATA: begin
                state_d = S_W_DATA;
            end
            S_W_DATA: begin
                if (tx_done_i) begin
                    if (slot_v_q || rd_en_i) begin
                        launch = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The pending slot outranks a fresh strobe; a strobe arriving
        // while the slot is occupied is lost.
        if (launch) begin
            if (slot_v_q) begin
                launch_addr = slot_addr_q;
                slot_v_d    = 1'b0;
                ovf_set     = rd_en_i;
            end
            addr_d    = launch_addr;
            tx_data_d = launch_addr;
            state_d   = S_TX_ADDR;
        end else if (rd_en_i) begin
            if (slot_v_q) begin
                ovf_set = 1'b1;
            end else begin
                slot_v_d    = 1'b1;
                slot_addr_d = addr_i;
            end
        end
    end

    always_comb begin
        status_d = status_clr ? 2'b00 : status_q;
        if (ovf_set) begin
            status_d[STATUS_RD_OVF_BIT] = 1'b1;
        end
        if (wr_en_i && !wr_ok) begin
            status_d[STATUS_WR_OOR_BIT] = 1'b1;
        end
        upd_d      = wr_ok;
        upd_addr_d = wr_ok ? addr_i : upd_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= 8'h00;
            snap_q      <= 8'h00;
            tx_data_q   <= 8'h00;
            slot_v_q    <= 1'b0;
            slot_addr_q <= 8'h00;
            status_q    <= 2'b00;
            upd_q       <= 1'b0;
            upd_addr_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            snap_q      <= snap_d;
            tx_data_q   <= tx_data_d;
            slot_v_q    <= slot_v_d;
            slot_addr_q <= slot_addr_d;
            status_q    <= status_d;
            upd_q       <= upd_d;
            upd_addr_q  <= upd_addr_d;
        end
    end

    assign tx_start_o = (state_q == S_TX_ADDR) || (state_q == S_TX_DATA);
    assign tx_data_o  = tx_data_q;
    assign busy_o     = (state_q != S_IDLE);
    assign upd_o      = upd_q;
    assign upd_addr_o = upd_addr_q;

endmodule

// File: doc/reg_bank_ctrl.md
Name: reg_bank_ctrl

Overview:
- Register bank and read-response scheduler behind the UART command decoder.
- Consumes the decoder's one-cycle write/read strobes with address and data, and holds the waveform-generator configuration registers.
- Serialises read responses onto the UART transmitter as a two-byte frame (address, data) using the transmitter's start/done handshake.
- Sits between the command decoder, the UART TX, and the waveform core.

Parameters:
- NUM_REGS, 16: number of 8-bit configuration registers, addresses 0..NUM_REGS-1. Legal range 1..255.
- ERR_BYTE, 8'hEE: data byte returned for reads of unmapped addresses.
- STATUS_ADDR, 8'hFF: address of the read-only status register. Must be ≥ NUM_REGS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en_i  in  1  one-cycle write strobe.
- rd_en_i  in  1  one-cycle read strobe.
- addr_i  in  8  register address, valid with either strobe.
- wdata_i  in  8  write data, valid with wr_en_i.
- tx_done_i  in  1  one-cycle pulse: UART finished the current byte.
- tx_start_o  out  1  one-cycle pulse: transmit tx_data_o.
- tx_data_o  out  8  byte to transmit; stable from tx_start_o until the matching tx_done_i.
- regs_o  out  NUM_REGS*8  flat register bank; register k occupies bits [8k+7:8k].
- upd_o  out  1  one-cycle pulse: a register was written.
- upd_addr_o  out  8  address of the last write, valid with upd_o.
- busy_o  out  1  response sequencer not idle.

Behaviour:
- Reset: all registers, tx_start_o, tx_data_o, upd_o, upd_addr_o and busy_o are 0. Status bits are cleared, the pending slot is empty, and the FSM is in S_IDLE. Asserting rst mid-frame aborts the frame immediately; no further tx_start_o is issued.
- Write, wr_en_i in cycle N with addr_i < NUM_REGS:
  - register updated at edge N+1;
  - upd_o = 1 and upd_addr_o = addr_i during cycle N+1.
- Write to addr_i ≥ NUM_REGS (including STATUS_ADDR): ignored, no upd_o, sets sticky status bit1 (WR_OOR).
- Simultaneous wr_en_i and rd_en_i in the same cycle: both are processed. The write takes effect first, so a same-address read returns the new value.
- Status register (STATUS_ADDR):
  - bit0 RD_OVF (read dropped);
  - bit1 WR_OOR;
  - bits7:2 = 0;
  - cleared in the cycle its value is snapshotted for a response (clear-on-read); a set event in that same cycle wins.
- Read acceptance:
  - FSM idle and slot empty: the request launches directly.
  - Otherwise the address is stored in a 1-deep pending slot.
  - Slot already full: the request is dropped and RD_OVF is set.
- FSM states: S_IDLE, S_TX_ADDR, S_W_ADDR, S_TX_DATA, S_W_DATA.
  - S_IDLE -> S_TX_ADDR when a read is accepted (rd_en_i, or pending slot non-empty; the slot has priority). The address is latched on entry.
  - S_TX_ADDR: tx_start_o = 1 for one cycle, tx_data_o = address; go to S_W_ADDR. The data byte is snapshotted in this cycle:
    - register value for a mapped address;
    - status for STATUS_ADDR;
    - ERR_BYTE for anything else.
  - S_W_ADDR -> S_TX_DATA on tx_done_i.
  - S_TX_DATA: tx_start_o = 1 for one cycle, tx_data_o = snapshot; go to S_W_DATA.
  - S_W_DATA on tx_done_i:
    - pending slot full -> S_TX_ADDR, taking the slot's address;
    - else rd_en_i this cycle -> S_TX_ADDR;
    - else S_IDLE.
- Latency: rd_en_i in cycle N from idle gives tx_start_o in cycle N+1 (registered outputs).
- A write after the snapshot does not alter the in-flight data byte.
- busy_o = (state != S_IDLE).
- tx_done_i outside S_W_ADDR/S_W_DATA is ignored.
- No combinational path from inputs to tx_start_o or tx_data_o.

Decomposition:
- Shared package wfg_pkg:
  - state_t enum {S_IDLE, S_TX_ADDR, S_W_ADDR, S_TX_DATA, S_W_DATA};
  - localparams STATUS_RD_OVF_BIT = 0 and STATUS_WR_OOR_BIT = 1;
  - CMD_* opcodes, moved there so the decoder and this block share one definition.
- One natural sub-module, reg_bank_file: the NUM_REGS×8 storage with write port, flat output and an asynchronous read mux.
- The FSM, pending slot and status logic stay in reg_bank_ctrl.

Test Plan:
1. Reset, then wr_en_i with addr 3, data 8'h5A -> regs_o[31:24] = 8'h5A next cycle, upd_o pulse with upd_addr_o = 3, no tx_start_o.
2. Read addr 3 from idle, tx_done_i 10 cycles after each start -> tx_start_o one cycle after rd_en_i with tx_data_o = 8'h03, then a second start with 8'h5A, then busy_o = 0.
3. Three back-to-back reads (addr 1, 2, 4) during an active frame -> frames for 1 and 2 sent in order; addr 4 dropped. A subsequent STATUS_ADDR read returns 8'h01, and reading it again returns 8'h00.
4. Write addr 20 (NUM_REGS = 16), then read addr 20 -> no upd_o and regs_o unchanged; response is 8'h14, ERR_BYTE (8'hEE); status bit1 set.
5. Read addr 5 (value 8'h11), then write addr 5 = 8'h22 one cycle after the snapshot -> data byte sent is 8'h11, regs_o shows 8'h22.
6. Assert rst between the two bytes of a frame -> outputs return to 0 immediately, no second tx_start_o, and the next read after reset behaves as in scenario 2.
